// File: rtl/fabric_stimulus_driver.sv
// ---------------------------------------------------------------------------
// fabric_stimulus_driver
//
// Stimulus side of the fabric test harness. A start pulse in IDLE serially
// shifts the CONFIG_WIDTH-bit bitstream into the fabric config chain, bit 0
// first. The block then walks the external vector memory. For each vector it
// drives datain together with the matching expected_dataout, holds them for
// SETTLE_CYCLES cycles, and moves on. After the last vector it parks in DONE
// with sim_done raised.
//
// Ports
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   start                one-cycle run request, honoured only in IDLE
//   config_bits          bitstream to load, held stable while busy
//   vec_rd_en, vec_addr  vector memory read strobe/address (data one cycle later)
//   vec_datain           fabric input field of the vector read back
//   vec_expected         expected fabric output field of the same vector
//   config_en, config_in config chain shift enable / serial data
//   datain               fabric data inputs
//   expected_dataout     expected fabric outputs for the scoreboard
//   expected_config_out  expected chain tail bit for the scoreboard
//   busy                 run in progress (not IDLE, not DONE)
//   sim_done             sticky end-of-run flag
// All outputs are registered.
// ---------------------------------------------------------------------------
module fabric_stimulus_driver #(
    parameter int DATA_IN_WIRE_WIDTH  = 8,
    parameter int DATA_OUT_WIRE_WIDTH = 8,
    parameter int CONFIG_WIDTH        = 64,
    parameter int NUM_VECTORS         = 16,
    parameter int SETTLE_CYCLES       = 4,
    localparam int ADDR_W             = $clog2(NUM_VECTORS) + 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [CONFIG_WIDTH-1:0]        config_bits,
    output logic                           vec_rd_en,
    output logic [ADDR_W-1:0]              vec_addr,
    input  logic [DATA_IN_WIRE_WIDTH-1:0]  vec_datain,
    input  logic [DATA_OUT_WIRE_WIDTH-1:0] vec_expected,
    output logic                           config_en,
    output logic                           config_in,
    output logic [DATA_IN_WIRE_WIDTH-1:0]  datain,
    output logic [DATA_OUT_WIRE_WIDTH-1:0] expected_dataout,
    output logic                           expected_config_out,
    output logic                           busy,
    output logic                           sim_done
);

    localparam int CNT_W  = $clog2(CONFIG_WIDTH + 1);
    localparam int HOLD_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CFG_LAST    = CNT_W'(CONFIG_WIDTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST    = ADDR_W'(NUM_VECTORS - 1);
    localparam bit                NO_VECTORS  = (NUM_VECTORS == 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_FETCH = 3'd3,
        ST_WAIT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;

    // cnt_r counts bits already driven onto the chain, so LOAD ends when it
    // reaches CONFIG_WIDTH. sh_r holds the bits still to be shifted out.
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_nxt_s;
    logic [CONFIG_WIDTH-1:0]  sh_r;
    logic [CONFIG_WIDTH-1:0]  sh_nxt_s;
    logic [HOLD_W-1:0]        hold_r;
    logic [HOLD_W-1:0]        hold_nxt_s;
    logic [ADDR_W-1:0]        idx_r;
    logic [ADDR_W-1:0]        idx_nxt_s;

    logic                           vec_rd_en_r,  vec_rd_en_nxt_s;
    logic [ADDR_W-1:0]              vec_addr_r,   vec_addr_nxt_s;
    logic                           config_en_r,  config_en_nxt_s;
    logic                           config_in_r,  config_in_nxt_s;
    logic [DATA_IN_WIRE_WIDTH-1:0]  datain_r,     datain_nxt_s;
    logic [DATA_OUT_WIRE_WIDTH-1:0] exp_dout_r,   exp_dout_nxt_s;
    logic                           exp_cfg_r,    exp_cfg_nxt_s;
    logic                           busy_r,       busy_nxt_s;
    logic                           sim_done_r,   sim_done_nxt_s;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_r == CFG_LAST) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_GAP: begin
                if (NO_VECTORS) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt_s = ST_WAIT;
            ST_WAIT:  state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (hold_r == HOLD_LAST) begin
                    if (idx_r == IDX_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DONE:  state_nxt_s = ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and counter next values. Outputs are computed from the state
    // being entered so that the registered outputs line up with that state.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        sh_nxt_s        = sh_r;
        hold_nxt_s      = hold_r;
        idx_nxt_s       = idx_r;
        config_in_nxt_s = 1'b0;
        datain_nxt_s    = datain_r;
        exp_dout_nxt_s  = exp_dout_r;
        exp_cfg_nxt_s   = exp_cfg_r;

        // Chain shifting: the IDLE->LOAD edge drives bit 0 straight from
        // config_bits; later bits come from the shift register.
        if ((state_r == ST_IDLE) && (state_nxt_s == ST_LOAD)) begin
            cnt_nxt_s       = CNT_W'(1);
            sh_nxt_s        = config_bits >> 1;
            idx_nxt_s       = '0;
            config_in_nxt_s = config_bits[0];
        end else if ((state_r == ST_LOAD) && (state_nxt_s == ST_LOAD)) begin
            cnt_nxt_s       = cnt_r + CNT_W'(1);
            sh_nxt_s        = sh_r >> 1;
            config_in_nxt_s = sh_r[0];
        end else begin
            config_in_nxt_s = 1'b0;
        end

        // The chain tail shows bit 0 once the whole stream has been loaded.
        if ((state_r == ST_LOAD) && (state_nxt_s == ST_GAP)) begin
            exp_cfg_nxt_s = config_bits[0];
        end else begin
            exp_cfg_nxt_s = exp_cfg_r;
        end

        // Vector index: first vector after GAP, next one after each HOLD.
        if (state_r == ST_GAP) begin
            idx_nxt_s = '0;
        end else if ((state_r == ST_HOLD) && (state_nxt_s == ST_FETCH)) begin
            idx_nxt_s = idx_r + ADDR_W'(1);
        end else begin
            idx_nxt_s = idx_nxt_s;
        end

        // Memory data is valid during WAIT. It is captured on WAIT's closing edge.
        if (state_r == ST_WAIT) begin
            datain_nxt_s   = vec_datain;
            exp_dout_nxt_s = vec_expected;
            hold_nxt_s     = '0;
        end else if ((state_r == ST_HOLD) && (state_nxt_s == ST_HOLD)) begin
            hold_nxt_s     = hold_r + HOLD_W'(1);
        end else begin
            hold_nxt_s     = hold_r;
        end

        vec_rd_en_nxt_s = (state_nxt_s == ST_FETCH);
        if (state_nxt_s == ST_FETCH) begin
            vec_addr_nxt_s = idx_nxt_s;
        end else begin
            vec_addr_nxt_s = vec_addr_r;
        end
        config_en_nxt_s = (state_nxt_s == ST_LOAD);
        busy_nxt_s      = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
        sim_done_nxt_s  = (state_nxt_s == ST_DONE);
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r       <= '0;
            sh_r        <= '0;
            hold_r      <= '0;
            idx_r       <= '0;
            vec_rd_en_r <= 1'b0;
            vec_addr_r  <= '0;
            config_en_r <= 1'b0;
            config_in_r <= 1'b0;
            datain_r    <= '0;
            exp_dout_r  <= '0;
            exp_cfg_r   <= 1'b0;
            busy_r      <= 1'b0;
            sim_done_r  <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            sh_r        <= sh_nxt_s;
            hold_r      <= hold_nxt_s;
            idx_r       <= idx_nxt_s;
            vec_rd_en_r <= vec_rd_en_nxt_s;
            vec_addr_r  <= vec_addr_nxt_s;
            config_en_r <= config_en_nxt_s;
            config_in_r <= config_in_nxt_s;
            datain_r    <= datain_nxt_s;
            exp_dout_r  <= exp_dout_nxt_s;
            exp_cfg_r   <= exp_cfg_nxt_s;
            busy_r      <= busy_nxt_s;
            sim_done_r  <= sim_done_nxt_s;
        end
    end

    assign vec_rd_en           = vec_rd_en_r;
    assign vec_addr            = vec_addr_r;
    assign config_en           = config_en_r;
    assign config_in           = config_in_r;
    assign datain              = datain_r;
    assign expected_dataout    = exp_dout_r;
    assign expected_config_out = exp_cfg_r;
    assign busy                = busy_r;
    assign sim_done            = sim_done_r;

endmodule

// File: tb/tb_fabric_stimulus_driver.sv
// ---------------------------------------------------------------------------
// Bench for fabric_stimulus_driver. There are two instances: one with five
// vectors and one with none. Both share clock, reset, start and bitstream.
// A timeline model derives the expected outputs for every cycle of a run
// from its cycle number. A table of runs varies the bitstream, the vector
// memory and stray start pulses. Hand sequences cover asynchronous reset in
// the middle of a hold.
// ---------------------------------------------------------------------------
module tb_fabric_stimulus_driver;

    localparam int CW  = 8;
    localparam int NV  = 5;
    localparam int S   = 4;
    localparam int P   = S + 2;
    localparam int AW  = $clog2(NV) + 1;
    localparam int RUN_LEN = CW + 2 + NV * P + 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic [CW-1:0] cfg_bits = '0;

    logic          m_rd, m_cen, m_cin, m_ecfg, m_busy, m_done;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_din, m_dexp;
    logic          z_rd, z_cen, z_cin, z_ecfg, z_busy, z_done;
    logic [0:0]    z_addr;
    logic [7:0]    z_din, z_dexp;

    logic [7:0] mem_in  [NV];
    logic [7:0] mem_exp [NV];
    logic [7:0] rd_in  = 8'h00;
    logic [7:0] rd_exp = 8'h00;
    logic [7:0] z_junk_in  = 8'hEE;
    logic [7:0] z_junk_exp = 8'h77;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fabric_stimulus_driver #(
        .DATA_IN_WIRE_WIDTH(8), .DATA_OUT_WIRE_WIDTH(8),
        .CONFIG_WIDTH(CW), .NUM_VECTORS(NV), .SETTLE_CYCLES(S)
    ) u_main (
        .clk(clk), .resetn(resetn), .start(start), .config_bits(cfg_bits),
        .vec_rd_en(m_rd), .vec_addr(m_addr), .vec_datain(rd_in), .vec_expected(rd_exp),
        .config_en(m_cen), .config_in(m_cin), .datain(m_din), .expected_dataout(m_dexp),
        .expected_config_out(m_ecfg), .busy(m_busy), .sim_done(m_done)
    );

    fabric_stimulus_driver #(
        .DATA_IN_WIRE_WIDTH(8), .DATA_OUT_WIRE_WIDTH(8),
        .CONFIG_WIDTH(CW), .NUM_VECTORS(0), .SETTLE_CYCLES(S)
    ) u_zero (
        .clk(clk), .resetn(resetn), .start(start), .config_bits(cfg_bits),
        .vec_rd_en(z_rd), .vec_addr(z_addr), .vec_datain(z_junk_in), .vec_expected(z_junk_exp),
        .config_en(z_cen), .config_in(z_cin), .datain(z_din), .expected_dataout(z_dexp),
        .expected_config_out(z_ecfg), .busy(z_busy), .sim_done(z_done)
    );

    // Vector memory with a one-cycle registered read.
    always @(posedge clk) begin
        if (m_rd) begin
            rd_in  <= mem_in[int'(m_addr)];
            rd_exp <= mem_exp[int'(m_addr)];
        end
    end

    typedef struct packed {
        logic       cen;
        logic       cin;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] din;
        logic [7:0] dexp;
        logic       ecfg;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic [CW-1:0] cfg;
        bit            fixed_mem;
        int            glitch_k;
        logic          exp_tail;
        int            exp_done_main;
        int            exp_done_zero;
    } run_t;

    // Expected outputs in cycle k of a run (k=1 is the first cycle after
    // the edge that sampled start; k=0 is idle before the run).
    function automatic obs_t model(int k, int nv, logic [CW-1:0] cfg);
        obs_t e;
        int done_k;
        e = '0;
        done_k = CW + 2 + nv * P;
        if (k >= 1 && k <= CW) begin
            e.cen  = 1'b1;
            e.cin  = cfg[k-1];
            e.busy = 1'b1;
        end
        if (k >= CW + 1) e.ecfg = cfg[0];
        if (k == CW + 1) e.busy = 1'b1;
        if (k >= CW + 2 && k < done_k) begin
            e.busy = 1'b1;
            if ((k - (CW + 2)) % P == 0) begin
                e.rd   = 1'b1;
                e.addr = 4'((k - (CW + 2)) / P);
            end
        end
        for (int v = 0; v < nv; v++) begin
            if (k >= CW + 2 + v * P + 2) begin
                e.din  = mem_in[v];
                e.dexp = mem_exp[v];
            end
        end
        if (k >= 1 && k >= done_k) e.done = 1'b1;
        return e;
    endfunction

    function automatic obs_t obs_main();
        obs_t a;
        a.cen = m_cen; a.cin = m_cin; a.rd = m_rd;
        a.addr = m_rd ? 4'(m_addr) : 4'h0;
        a.din = m_din; a.dexp = m_dexp; a.ecfg = m_ecfg; a.busy = m_busy; a.done = m_done;
        return a;
    endfunction

    function automatic obs_t obs_zero();
        obs_t a;
        a.cen = z_cen; a.cin = z_cin; a.rd = z_rd;
        a.addr = z_rd ? {3'b000, z_addr} : 4'h0;
        a.din = z_din; a.dexp = z_dexp; a.ecfg = z_ecfg; a.busy = z_busy; a.done = z_done;
        return a;
    endfunction

    task automatic chk(input string name, input int k, input obs_t act, input obs_t exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s cycle %0d: got %h required %h (cen,cin,rd,addr,din,dexp,ecfg,busy,done)",
                     name, k, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // One complete run, compared cycle by cycle against the model.
    task automatic do_run(input run_t r);
        int first_m;
        int first_z;
        first_m = -1;
        first_z = -1;
        do_reset();
        cfg_bits = r.cfg;
        for (int v = 0; v < NV; v++) begin
            if (r.fixed_mem) begin
                mem_in[v]  = 8'(2 * v + 1);
                mem_exp[v] = 8'(2 * v + 2);
            end else begin
                mem_in[v]  = 8'($urandom);
                mem_exp[v] = 8'($urandom);
            end
        end
        chk("idle_main", 0, obs_main(), model(0, NV, r.cfg));
        chk("idle_zero", 0, obs_zero(), model(0, 0, r.cfg));
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= RUN_LEN; k++) begin
            chk("run_main", k, obs_main(), model(k, NV, r.cfg));
            chk("run_zero", k, obs_zero(), model(k, 0, r.cfg));
            if (m_done && first_m < 0) first_m = k;
            if (z_done && first_z < 0) first_z = k;
            start = (k == r.glitch_k);
            @(negedge clk);
        end
        start = 1'b0;
        chk_int("done_cycle_main", first_m, r.exp_done_main);
        chk_int("done_cycle_zero", first_z, r.exp_done_zero);
        chk_int("config_tail", int'(m_ecfg), int'(r.exp_tail));
    endtask

    run_t runs[5];
    obs_t zero_obs;

    initial begin
        runs[0] = '{8'hA5, 1'b1, 0,  1'b1, 40, 10};
        runs[1] = '{8'h5A, 1'b0, 3,  1'b0, 40, 10};
        runs[2] = '{8'h3C, 1'b0, 42, 1'b0, 40, 10};
        runs[3] = '{8'hFF, 1'b0, 20, 1'b1, 40, 10};
        runs[4] = '{8'h01, 1'b0, 9,  1'b1, 40, 10};
        zero_obs = '0;

        for (int i = 0; i < 5; i++) begin
            do_run(runs[i]);
        end

        // Asynchronous reset in the middle of the first vector's hold.
        do_reset();
        cfg_bits = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < CW + 5; k++) @(negedge clk);
        chk("pre_reset_busy", CW + 5, obs_main(), model(CW + 5, NV, 8'hC3));
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_main", 0, obs_main(), zero_obs);
        chk("async_reset_zero", 0, obs_zero(), zero_obs);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stay_idle_main", k, obs_main(), zero_obs);
        end

        // A clean rerun after the abandoned one.
        do_run(runs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
